sha256_round_ctrl: RTL and testbench
====================================

SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 64, meaning the number of compression rounds per block; only 64 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, a request to compress one block; sampled only in IDLE.
REQ-005 SHALL have port init_sel, input, 1, sampled with start: 1 = load the FIPS 180-4 IV into H, 0 = chain from the current H.
REQ-006 SHALL have port w_valid, input, 1, meaning schedule word W_t is valid.
REQ-007 SHALL have port w_data, input, 32, carrying schedule word W_t.
REQ-008 SHALL have port w_ready, output, 1, meaning the controller accepts W_t this cycle.
REQ-009 SHALL have port round_idx, output, 6, giving the index t of the word requested.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse when the digest is updated.
REQ-012 SHALL have port digest, output, 256, holding H0..H7 with H0 in [255:224].

Function
REQ-013 SHALL implement the FSM IDLE -> LOAD -> ROUND -> FINAL -> IDLE.
- IDLE -> LOAD on start.
- LOAD -> ROUND unconditionally.
- ROUND -> FINAL on the handshake at t=63.
- FINAL -> IDLE unconditionally.
REQ-014 LOAD SHALL:
- write H <= IV when init_sel=1;
- write a..h <= the selected H (IV or current);
- clear t to 0.
REQ-015 w_ready SHALL be 1 only in ROUND; a handshake is w_valid & w_ready.
REQ-016 On each handshake the block SHALL:
- apply one round using Sigma0(a) = ROTR2^ROTR13^ROTR22, Sigma1(e), Ch, Maj, K[t] and w_data;
- perform all additions mod 2^32;
- increment t.
REQ-017 With w_valid=0 in ROUND, a..h and t SHALL hold.
REQ-018 FINAL SHALL write Hi <= Hi + working variable i, mod 2^32 per word.
REQ-019 done SHALL be registered and high for exactly the cycle after FINAL.
REQ-020 Minimum start-to-done latency SHALL be 66 cycles plus one cycle per stall cycle.
REQ-021 start while busy SHALL be ignored, with no effect on the block in progress.
REQ-022 w_valid outside ROUND SHALL be ignored.
REQ-023 round_idx SHALL equal t in ROUND and 0 otherwise.
REQ-024 digest SHALL change only in LOAD (when init_sel=1) and in FINAL.

Reset
REQ-025 rst_n low SHALL asynchronously force:
- state to IDLE;
- t = 0;
- a..h = 0 and H = 0;
- busy = 0, done = 0, w_ready = 0.
REQ-026 Reset mid-block SHALL discard the block; after release only start is acted on.

Configuration
REQ-027 With SHA256_CTRL_ABORT_EN defined, the block SHALL:
- add input abort (1 bit);
- on abort in LOAD, ROUND or FINAL, return to IDLE next cycle with H unchanged and no done;
- let abort win over a simultaneous t=63 handshake or FINAL update.
REQ-028 Without SHA256_CTRL_ABORT_EN, the abort port and its logic SHALL be absent.

Structure
REQ-029 Package sha256_pkg SHALL hold:
- the state enum;
- the K[0..63] constant array;
- the IV H0..H7;
- the word and digest width constants.
REQ-030 Sub-module sha256_round_fn SHALL be the combinational single-round function, built from the existing EP0, EP1, CH and MAJ blocks; the controller holds all registers.

Verification
REQ-031 "abc" padded block with init_sel=1 and no stalls -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with done exactly 66 cycles after start.
REQ-032 Same block with w_valid deasserted on 20 random cycles -> same digest, done at cycle 86, a..h unchanged across each stall.
REQ-033 Two-block "abcdbcdecdefdefg...nopq" message, block 1 with init_sel=1 and block 2 with init_sel=0 -> digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-034 start pulsed at t=10 and t=63 -> ignored, one done, digest identical to REQ-031.
REQ-035 rst_n low at t=30, then "abc" with init_sel=1 -> immediately after reset digest=0 and busy=0, final digest as in REQ-031.
REQ-036 (SHA256_CTRL_ABORT_EN) abort on the t=63 handshake cycle -> no done pulse, digest equal to its pre-start value, IDLE next cycle.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 controller types: FSM states, round constants, IV and the
// EP0/EP1/CH/MAJ primitive functions used by the round datapath.
package sha256_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned DIGEST_W = 256;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL
    } state_e;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [DIGEST_W-1:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t ep0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t ep1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round_fn.sv
// Combinational single SHA-256 compression round over the packed working
// variables a..h (a in the top word).
module sha256_round_fn
    import sha256_pkg::*;
(
    input  logic [DIGEST_W-1:0] state_i,
    input  word_t               k_i,
    input  word_t               w_i,
    output logic [DIGEST_W-1:0] state_o
);

    word_t a, b, c, d, e, f, g, h;
    word_t t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_i;

    always_comb begin
        t1      = h + ep1(e) + ch(e, f, g) + k_i + w_i;
        t2      = ep0(a) + maj(a, b, c);
        state_o = {t1 + t2, a, b, c, d + t1, e, f, g};
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block compression controller: holds H and a..h, consumes one W_t per
// handshake. Optional `SHA256_CTRL_ABORT_EN adds an abort input.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                init_sel,
    input  logic                w_valid,
    input  logic [WORD_W-1:0]   w_data,
`ifdef SHA256_CTRL_ABORT_EN
    input  logic                abort,
`endif
    output logic                w_ready,
    output logic [5:0]          round_idx,
    output logic                busy,
    output logic                done,
    output logic [DIGEST_W-1:0] digest
);

    state_e              state_q, state_d;
    logic [5:0]          t_q, t_d;
    logic [DIGEST_W-1:0] work_q, work_d;
    logic [DIGEST_W-1:0] h_q, h_d;
    logic                init_q, init_d;
    logic                done_q, done_d;
    logic [DIGEST_W-1:0] round_out;

    sha256_round_fn u_round (
        .state_i (work_q),
        .k_i     (K[t_q]),
        .w_i     (w_data),
        .state_o (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            work_q  <= '0;
            h_q     <= '0;
            init_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            work_q  <= work_d;
            h_q     <= h_d;
            init_q  <= init_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        work_d  = work_q;
        h_d     = h_q;
        init_d  = init_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    init_d  = init_sel;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (init_q) begin
                    h_d = IV;
                end
                work_d  = init_q ? IV : h_q;
                t_d     = '0;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                if (w_valid) begin
                    work_d = round_out;
                    t_d    = t_q + 6'd1;
                    if (t_q == 6'(ROUNDS - 1)) begin
                        state_d = ST_FINAL;
                    end
                end
            end
            ST_FINAL: begin
                for (int unsigned i = 0; i < 8; i++) begin
                    h_d[DIGEST_W-1-WORD_W*i -: WORD_W] = h_q[DIGEST_W-1-WORD_W*i -: WORD_W]
                                                       + work_q[DIGEST_W-1-WORD_W*i -: WORD_W];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef SHA256_CTRL_ABORT_EN
        // Abort overrides whatever the case above scheduled, including the FINAL H update.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            h_d     = h_q;
            done_d  = 1'b0;
            t_d     = '0;
        end
`endif
    end

    assign busy      = (state_q != ST_IDLE);
    assign w_ready   = (state_q == ST_ROUND);
    assign round_idx = (state_q == ST_ROUND) ? t_q : '0;
    assign done      = done_q;
    assign digest    = h_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: table-driven block runs with known
// digests and latencies, plus start-while-busy, mid-block reset and abort.
module tb_sha256_round_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         init_sel = 1'b0;
    logic         w_valid = 1'b0;
    logic [31:0]  w_data = '0;
`ifdef SHA256_CTRL_ABORT_EN
    logic         abort = 1'b0;
`endif
    logic         w_ready;
    logic [5:0]   round_idx;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    sha256_round_ctrl #(.ROUNDS(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .init_sel  (init_sel),
        .w_valid   (w_valid),
        .w_data    (w_data),
`ifdef SHA256_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .w_ready   (w_ready),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done),
        .digest    (digest)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] DIG_IV  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] DIG_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    int checks = 0;
    int failures = 0;

    logic [31:0] msgs [3][16];
    logic [31:0] sched [64];

    typedef struct {
        int           mi;
        logic         init;
        int           stalls;
        int           exp_lat;
        bit           dchk;
        logic [255:0] dexp;
        bit           mchk;
        logic [255:0] mexp;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_sched(input int mi);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                sched[t] = msgs[mi][t];
            end else begin
                sched[t] = (rr(sched[t-2], 17) ^ rr(sched[t-2], 19) ^ (sched[t-2] >> 10))
                         + sched[t-7]
                         + (rr(sched[t-15], 7) ^ rr(sched[t-15], 18) ^ (sched[t-15] >> 3))
                         + sched[t-16];
            end
        end
    endtask

    // Runs one block; lat = edges from the start edge to done (-1 timeout,
    // -2 reset taken, -3 aborted).
    task automatic run_block(input string tag, input int mi, input logic init, input int stalls,
                             input int rst_at, input int abort_at, input bit pulse_start,
                             input bit mchk, input logic [255:0] mexp, output int lat);
        int  n;
        int  t_exp;
        int  stalls_left;
        bit  idx_bad;
        bit  mid_done;
        bit  stop;
        build_sched(mi);
        @(negedge clk);
        start    = 1'b1;
        init_sel = init;
        w_valid  = 1'b0;
        @(posedge clk);
        #1;
        start    = 1'b0;
        init_sel = ~init;
        n = 0; t_exp = 0; stalls_left = stalls; lat = -1;
        idx_bad = 1'b0; mid_done = 1'b0; stop = 1'b0;
        while (!stop && n < 300) begin
            @(negedge clk);
            start = 1'b0;
            if (w_ready) begin
                if (round_idx != 6'(t_exp)) idx_bad = 1'b1;
                if (mchk && !mid_done && t_exp == 32) begin
                    check({tag, "_mid_digest"}, digest, mexp);
                    mid_done = 1'b1;
                end
                if (t_exp == rst_at) begin
                    rst_n   = 1'b0;
                    w_valid = 1'b0;
                    #1;
                    check({tag, "_rst_digest"}, digest, '0);
                    check({tag, "_rst_busy"}, busy, 1'b0);
                    check({tag, "_rst_ready"}, w_ready, 1'b0);
                    check({tag, "_rst_idx"}, round_idx, 6'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    lat   = -2;
                    stop  = 1'b1;
                end else begin
                    if (pulse_start && (t_exp == 10 || t_exp == 63)) start = 1'b1;
                    if (stalls_left > 0 && ($urandom_range(0, 3) == 0 || stalls_left >= 64 - t_exp)) begin
                        w_valid = 1'b0;
                        w_data  = $urandom;
                        stalls_left--;
                    end else begin
                        w_valid = 1'b1;
                        w_data  = sched[t_exp];
`ifdef SHA256_CTRL_ABORT_EN
                        if (t_exp == abort_at) abort = 1'b1;
`endif
                        t_exp++;
                    end
                end
            end else begin
                w_valid = 1'b1;
                w_data  = $urandom;
            end
            if (!stop) begin
                @(posedge clk);
                n++;
                #1;
`ifdef SHA256_CTRL_ABORT_EN
                if (abort) begin
                    abort = 1'b0;
                    check({tag, "_abort_idle"}, busy, 1'b0);
                    check({tag, "_abort_done"}, done, 1'b0);
                    lat  = -3;
                    stop = 1'b1;
                end
`endif
                if (!stop && done) begin
                    lat  = n;
                    stop = 1'b1;
                end
            end
        end
        w_valid = 1'b0;
        start   = 1'b0;
        if (abort_at < 0) check({tag, "_round_idx_seq"}, idx_bad, 1'b0);
        if (rst_at < 0 && abort_at < 0) begin
            @(posedge clk);
            #1;
            check({tag, "_done_width"}, done, 1'b0);
            check({tag, "_idle_busy"}, busy, 1'b0);
        end
    endtask

    initial begin
        int lat;
        int extra_done;

        msgs[0] = '{0: 32'h61626380, 15: 32'h00000018, default: 32'h0};
        msgs[1] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        msgs[2] = '{15: 32'h000001c0, default: 32'h0};

        vecs[0] = '{0, 1'b1, 0,  66, 1'b1, DIG_ABC, 1'b1, DIG_IV};
        vecs[1] = '{0, 1'b1, 20, 86, 1'b1, DIG_ABC, 1'b1, DIG_IV};
        vecs[2] = '{1, 1'b1, 0,  66, 1'b0, '0,      1'b1, DIG_IV};
        vecs[3] = '{2, 1'b0, 3,  69, 1'b1, DIG_TWO, 1'b0, '0};

        #1;
        check("reset_digest", digest, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_ready", w_ready, 1'b0);
        check("reset_idx", round_idx, 6'd0);
        #13;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_block($sformatf("vec%0d", i), vecs[i].mi, vecs[i].init, vecs[i].stalls,
                      -1, -1, 1'b0, vecs[i].mchk, vecs[i].mexp, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].dchk) check($sformatf("vec%0d_digest", i), digest, vecs[i].dexp);
        end

        // start pulses while busy must be ignored
        run_block("busy_start", 0, 1'b1, 0, -1, -1, 1'b1, 1'b1, DIG_IV, lat);
        check("busy_start_latency", lat, 66);
        check("busy_start_digest", digest, DIG_ABC);
        extra_done = 0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra_done++;
        end
        check("busy_start_single_done", extra_done, 0);

        // reset in the middle of a block, then idle inputs other than start are ignored
        run_block("midrst", 0, 1'b1, 0, 30, -1, 1'b0, 1'b0, '0, lat);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            w_valid = 1'b1;
            w_data  = $urandom;
        end
        @(negedge clk);
        w_valid = 1'b0;
        check("midrst_post_busy", busy, 1'b0);
        check("midrst_post_digest", digest, '0);
        run_block("after_rst", 0, 1'b1, 0, -1, -1, 1'b0, 1'b0, '0, lat);
        check("after_rst_latency", lat, 66);
        check("after_rst_digest", digest, DIG_ABC);

`ifdef SHA256_CTRL_ABORT_EN
        run_block("abort63", 0, 1'b0, 0, -1, 63, 1'b0, 1'b1, DIG_ABC, lat);
        check("abort63_path", lat, -3);
        extra_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        check("abort63_no_done", extra_done, 0);
        check("abort63_digest", digest, DIG_ABC);
        check("abort63_busy", busy, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
